// File: rtl/priority_encode_log_pkg.sv
// Shared sizing helpers for the lowest-index-first priority encoder.
package priority_encode_log_pkg;

    // Default geometry: 1024 request slots encoded into a 10-bit index.
    localparam int DEFAULT_WIDTH     = 1024;
    localparam int DEFAULT_LOG_WIDTH = 10;

    // Number of leaves in the reduction tree once decode is zero-extended.
    function automatic int pad_width(input int log_width);
        return 1 << log_width;
    endfunction

endpackage

// File: rtl/priority_encode_log_pe_merge.sv
// One node of the priority reduction tree: merges a low half and a high half,
// the low half always winning when it has any request.
module pe_merge #(
    parameter  int K  = 1,
    localparam int KW = (K > 0) ? K : 1
) (
    input  logic          v_l_i,
    input  logic [KW-1:0] i_l_i,
    input  logic          v_h_i,
    input  logic [KW-1:0] i_h_i,
    output logic          v_o,
    output logic [K:0]    i_o
);

    assign v_o = v_l_i | v_h_i;

    if (K == 0) begin : g_leaf_pair
        // Leaves carry no index bits; the child indices are placeholders only.
        logic unused_idx;
        assign unused_idx = ^{i_l_i, i_h_i};
        assign i_o = v_l_i ? 1'b0 : 1'b1;
    end else begin : g_inner
        // New MSB records which half won; lower bits come from the winner.
        assign i_o = v_l_i ? {1'b0, i_l_i} : {1'b1, i_h_i};
    end

endmodule

// File: rtl/priority_encode_log.sv
// Lowest-index-first priority encoder over a wide request vector.
// A log2-depth tree of pe_merge cells feeds a single output register.
//
// Interface: valid qualifies encode in the same cycle. There is no ready and
// no stall; a new decode vector is sampled on every rising clk edge and its
// result appears on encode/valid exactly one edge later.
module priority_encode_log
    import priority_encode_log_pkg::*;
#(
    parameter int width     = DEFAULT_WIDTH,
    parameter int log_width = DEFAULT_LOG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [width-1:0]     decode,
    output logic [log_width-1:0] encode,
    output logic                 valid
);

    localparam int FULL = pad_width(log_width);

    if (width > FULL || width < 1 || log_width < 1) begin : g_bad_size
        $error("priority_encode_log: width must be in [1, 2**log_width]");
    end

    // Zero-extend the request vector so the tree is a perfect binary tree;
    // padded bits are always 0 and therefore never win.
    logic [FULL-1:0] req;

    always_comb begin
        req               = '0;
        req[width-1:0]    = decode;
    end

    // Reduction tree: level l has FULL>>l nodes, each with an l-bit index.
    for (genvar l = 1; l <= log_width; l++) begin : g_lvl
        localparam int NODES = FULL >> l;
        logic [NODES-1:0]        v;
        logic [NODES-1:0][l-1:0] idx;

        for (genvar n = 0; n < NODES; n++) begin : g_node
            if (l == 1) begin : g_from_req
                pe_merge #(.K(0)) u_merge (
                    .v_l_i (req[2*n]),
                    .i_l_i (1'b0),
                    .v_h_i (req[2*n+1]),
                    .i_h_i (1'b0),
                    .v_o   (v[n]),
                    .i_o   (idx[n])
                );
            end else begin : g_from_lvl
                pe_merge #(.K(l-1)) u_merge (
                    .v_l_i (g_lvl[l-1].v[2*n]),
                    .i_l_i (g_lvl[l-1].idx[2*n]),
                    .v_h_i (g_lvl[l-1].v[2*n+1]),
                    .i_h_i (g_lvl[l-1].idx[2*n+1]),
                    .v_o   (v[n]),
                    .i_o   (idx[n])
                );
            end
        end
    end

    logic                 root_v;
    logic [log_width-1:0] root_i;

    assign root_v = g_lvl[log_width].v[0];
    assign root_i = g_lvl[log_width].idx[0];

    logic                 valid_d, valid_q;
    logic [log_width-1:0] encode_d, encode_q;

    // Next output: the root index, forced to 0 when nothing is requesting.
    always_comb begin
        valid_d  = root_v;
        encode_d = root_v ? root_i : '0;
    end

    // Output register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            encode_q <= '0;
        end else begin
            valid_q  <= valid_d;
            encode_q <= encode_d;
        end
    end

    assign valid  = valid_q;
    assign encode = encode_q;

endmodule

// File: tb/tb_priority_encode_log.sv
// Scoreboard bench for priority_encode_log (width=1024, log_width=10).
module tb_priority_encode_log;

    localparam int W  = 1024;
    localparam int LW = 10;

    logic          clk;
    logic          rst;
    logic [W-1:0]  decode;
    logic [LW-1:0] encode;
    logic          valid;

    // Expected {valid, encode} for each vector driven, oldest first.
    logic [LW:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    priority_encode_log #(.width(W), .log_width(LW)) dut (
        .clk    (clk),
        .rst    (rst),
        .decode (decode),
        .encode (encode),
        .valid  (valid)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: index of the first set bit scanning upward from bit 0.
    function automatic logic [LW:0] model(input logic [W-1:0] d);
        for (int i = 0; i < W; i++) begin
            if (d[i]) return {1'b1, LW'(i)};
        end
        return '0;
    endfunction

    function automatic logic [W-1:0] one_hot(input int k);
        logic [W-1:0] d;
        d    = '0;
        d[k] = 1'b1;
        return d;
    endfunction

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] d;
        int mode;
        int lo;
        d    = '0;
        mode = $urandom_range(0, 3);
        case (mode)
            0: for (int w = 0; w < W / 32; w++) d[w*32 +: 32] = $urandom();
            1: d[$urandom_range(0, W - 1)] = 1'b1;
            2: begin
                lo = $urandom_range(0, W - 1);
                for (int i = lo; i < W; i++) begin
                    if ($urandom_range(0, 15) == 0) d[i] = 1'b1;
                end
            end
            default: d = '0;
        endcase
        return d;
    endfunction

    task automatic check(input string name, input logic [LW:0] act, input logic [LW:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got valid=%0b encode=%0d, expected valid=%0b encode=%0d",
                     name, act[LW], act[LW-1:0], exp[LW], exp[LW-1:0]);
        end
    endtask

    // Driver: present a vector at the falling edge and record its expected result.
    task automatic drive(input logic [W-1:0] d);
        @(negedge clk);
        decode = d;
        exp_q.push_back(model(d));
    endtask

    // Monitor: after each rising edge, compare the registered output against the oldest expectation.
    initial begin
        logic [LW:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pipe", {valid, encode}, e);
            end
        end
    end

    // Stimulus
    initial begin
        logic [W-1:0] d;

        rst    = 1'b0;
        decode = '1;

        // Reset held with every bit requesting: outputs stay cleared across edges.
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_hold", {valid, encode}, '0);
        end

        // Release reset with an empty request vector.
        @(negedge clk);
        rst    = 1'b1;
        decode = '0;
        exp_q.push_back(model('0));

        // Single-bit requests, including the extreme indices.
        drive(one_hot(0));
        drive(one_hot(5));
        drive(one_hot(10));
        drive(one_hot(512));
        drive(one_hot(1023));

        // Multi-bit patterns in the low word.
        drive(W'(32'hFC));
        drive(W'(32'h3E0));
        drive(W'(32'hAAAAAAAA));
        drive(W'(32'hFFFFFFFF));

        // Sparse wide pattern, then back to empty.
        d       = '0;
        d[100]  = 1'b1;
        d[512]  = 1'b1;
        d[1023] = 1'b1;
        drive(d);
        drive('0);

        // Back-to-back random vectors.
        for (int n = 0; n < 300; n++) drive(rand_vec());

        // Asynchronous reset between edges while valid is high.
        drive(one_hot(7));
        @(posedge clk);
        #2;
        check("valid_before_reset", {valid, encode}, {1'b1, LW'(7)});
        decode = one_hot(9);
        rst    = 1'b0;
        #1;
        check("async_clear", {valid, encode}, '0);
        @(posedge clk);
        #1;
        check("reset_hold_mid", {valid, encode}, '0);

        // Release mid-stream: the very next edge registers the current decode.
        @(negedge clk);
        rst    = 1'b1;
        decode = one_hot(300);
        exp_q.push_back(model(one_hot(300)));
        for (int n = 0; n < 20; n++) drive(rand_vec());

        // Drain with a bounded wait.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
